// File: rtl/syup_counter.sv
// Ripple up counter: a chain of toggle stages, stage 0 clocked by clk and each
// later stage clocked by the inverted output of the stage before it.
module syup_counter #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] count_out
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      logic q;
      logic tick;

      // A stage advances when its predecessor falls 1 -> 0, which is the carry
      // into this bit; inversion is the only logic allowed in the clock path.
      if (i == 0) begin : g_first
         assign tick = clk;
      end else begin : g_next
         assign tick = ~g_stage[i-1].q;
      end

      // NOTE: non-blocking assignment for flop state, even with a single flop
      // per block, keeps every stage free of simulation ordering races.
      always_ff @(posedge tick or posedge reset) begin
         if (reset) begin
            q <= 1'b0;
         end else begin
            q <= ~q;
         end
      end

      assign count_out[i] = q;
   end

endmodule

// File: tb/tb_syup_counter.sv
// Directed bench for syup_counter at WIDTH 3, 4 and 1 sharing one clock and reset.
module tb_syup_counter;

   logic       clk;
   logic       reset;
   logic [2:0] cnt3;
   logic [3:0] cnt4;
   logic [0:0] cnt1;

   int total = 0;
   int bad   = 0;

   syup_counter #(.WIDTH(3)) dut3 (.clk(clk), .reset(reset), .count_out(cnt3));
   syup_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .count_out(cnt4));
   syup_counter #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .count_out(cnt1));

   // Rising edges at 5, 15, 25, ... ns; falling edges at 10, 20, ... ns.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input int n);
      check({tag, "_w3"}, 16'(cnt3), 16'(n % 8));
      check({tag, "_w4"}, 16'(cnt4), 16'(n % 16));
      check({tag, "_w1"}, 16'(cnt1), 16'(n % 2));
   endtask

   initial begin
      logic [2:0] prev;
      int toggles[3];
      int highs[3];

      reset = 1'b1;
      foreach (toggles[b]) begin
         toggles[b] = 0;
         highs[b]   = 0;
      end

      // Reset hold: clock runs, counters stay at zero (samples at 10..50 ns).
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_all("reset_hold", 0);
      end
      reset = 1'b0;  // released at 50 ns, first count on the 55 ns edge

      // Count-up, wrap and divider: 64 edges is eight full WIDTH=3 wraps.
      prev = 3'd0;
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         check_all("count", k);
         for (int b = 0; b < 3; b++) begin
            if (cnt3[b] !== prev[b]) toggles[b]++;
            if (cnt3[b] === 1'b1) highs[b]++;
         end
         prev = cnt3;
      end
      check("div_toggle_b0", 16'(toggles[0]), 16'd64);
      check("div_toggle_b1", 16'(toggles[1]), 16'd32);
      check("div_toggle_b2", 16'(toggles[2]), 16'd16);
      check("duty_b0", 16'(highs[0]), 16'd32);
      check("duty_b1", 16'(highs[1]), 16'd32);
      check("duty_b2", 16'(highs[2]), 16'd32);

      // Advance to count 4 (a 3 -> 4 full ripple), then reset between edges.
      for (int k = 65; k <= 67; k++) begin
         @(negedge clk);
         check_all("pre_reset", k);
      end
      @(posedge clk);
      #1 check_all("at_four", 68);
      #1 reset = 1'b1;                     // edge + 2 ns
      #1 check_all("async_clear", 0);      // edge + 3 ns, no clock edge yet
      @(posedge clk);
      #1 check_all("edge_in_reset", 0);    // edge during reset is ignored
      #6 reset = 1'b0;                     // edge + 7 ns, 3 ns before next edge
      @(negedge clk);
      check_all("resume_1", 1);
      @(negedge clk);
      check_all("resume_2", 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
